// File: rtl/bus_protocol_pkg.sv
// Shared types and constants for the bus protocol monitor.
// Optional transfer counting is enabled by defining BUS_PROTOCOL_COUNT_EN.
package bus_protocol_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      ACKED,
      ABORT
   } ch_state_t;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/bus_protocol_monitor_if.sv
// Per-channel valid/ack/data bundle observed by bus_protocol_monitor.
interface bus_protocol_monitor_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 1
);

   logic [NUM_CH-1:0]             dValid;
   logic [NUM_CH-1:0]             dAck;
   logic [NUM_CH-1:0][DATA_W-1:0] data;

   modport master  (output dValid, output data, input  dAck);
   modport slave   (input  dValid, input  data, output dAck);
   modport monitor (input  dValid, input  data, input  dAck);

endinterface

// File: rtl/bus_protocol_ch_monitor.sv
// Single-channel protocol checker FSM with sticky error flags.
// xfer_cnt is a saturating clean-transfer counter only when BUS_PROTOCOL_COUNT_EN is defined.
module bus_protocol_ch_monitor
   import bus_protocol_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MIN_VALID = 2,
   parameter int unsigned MAX_VALID = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dValid,
   input  logic              dAck,
   input  logic [DATA_W-1:0] data,
   input  logic              clr_err,
   output logic              err_len,
   output logic              err_ack,
   output logic              err_data,
   output logic              done,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam logic [RUN_W-1:0] MIN_C = RUN_W'(MIN_VALID);
   localparam logic [RUN_W-1:0] MAX_C = RUN_W'(MAX_VALID);

   ch_state_t         state;
   logic [RUN_W-1:0]  cnt;
   logic [RUN_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] cap;
   logic              txn_err;

   assign cnt_inc = cnt + RUN_W'(1);

   // clr_err is applied first so a flag set later in the same cycle wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         cap      <= '0;
         txn_err  <= 1'b0;
         err_len  <= 1'b0;
         err_ack  <= 1'b0;
         err_data <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clr_err) begin
            err_len  <= 1'b0;
            err_ack  <= 1'b0;
            err_data <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (dAck) err_ack <= 1'b1;
               if (dValid) begin
                  cap     <= data;
                  cnt     <= RUN_W'(1);
                  txn_err <= 1'b0;
                  state   <= dAck ? ABORT : ACTIVE;
               end
            end
            ACTIVE: begin
               if (!dValid) begin
                  err_len <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt_inc;
                  if (data != cap) begin
                     err_data <= 1'b1;
                     txn_err  <= 1'b1;
                  end
                  if (dAck) begin
                     if (cnt_inc >= MIN_C) begin
                        state <= ACKED;
                     end else begin
                        err_ack <= 1'b1;
                        state   <= ABORT;
                     end
                  end else if (cnt_inc == MAX_C) begin
                     err_ack <= 1'b1;
                     state   <= ABORT;
                  end
               end
            end
            ACKED: begin
               if (dValid) begin
                  err_len <= 1'b1;
                  state   <= ABORT;
               end else begin
                  done  <= !txn_err;
                  state <= IDLE;
               end
            end
            default: begin
               if (!dValid) state <= IDLE;
            end
         endcase
      end
   end

`ifdef BUS_PROTOCOL_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xfer_cnt <= '0;
      end else if (done && (xfer_cnt != '1)) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end
`else
   assign xfer_cnt = '0;
`endif

endmodule

// File: rtl/bus_protocol_monitor.sv
// Multi-channel valid/ack protocol monitor; one checker per channel.
// Define BUS_PROTOCOL_COUNT_EN to enable the per-channel clean-transfer counters.
module bus_protocol_monitor
   import bus_protocol_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned NUM_CH    = 1,
   parameter int unsigned MIN_VALID = 2,
   parameter int unsigned MAX_VALID = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   bus_protocol_monitor_if.monitor        bus,
   input  logic                           clr_err,
   output logic [NUM_CH-1:0]              err_len,
   output logic [NUM_CH-1:0]              err_ack,
   output logic [NUM_CH-1:0]              err_data,
   output logic                           err_any,
   output logic [NUM_CH-1:0]              done,
   output logic [NUM_CH-1:0][CNT_W-1:0]   xfer_cnt
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      bus_protocol_ch_monitor #(
         .DATA_W    (DATA_W),
         .MIN_VALID (MIN_VALID),
         .MAX_VALID (MAX_VALID)
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .dValid   (bus.dValid[g]),
         .dAck     (bus.dAck[g]),
         .data     (bus.data[g]),
         .clr_err  (clr_err),
         .err_len  (err_len[g]),
         .err_ack  (err_ack[g]),
         .err_data (err_data[g]),
         .done     (done[g]),
         .xfer_cnt (xfer_cnt[g])
      );
   end

   assign err_any = (|err_len) | (|err_ack) | (|err_data);

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Scoreboard bench for bus_protocol_monitor (4 channels, default run limits 2..4).
module tb_bus_protocol_monitor;

   localparam int NCH = 4;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                clr_err = 1'b0;
   logic [NCH-1:0]      err_len, err_ack, err_data, done;
   logic                err_any;
   logic [NCH-1:0][15:0] xfer_cnt;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct { int ch; int cyc; } exp_t;
   exp_t exp_q[$];

   bus_protocol_monitor_if #(.DATA_W(8), .NUM_CH(NCH)) bus ();

   bus_protocol_monitor #(
      .DATA_W    (8),
      .NUM_CH    (NCH),
      .MIN_VALID (2),
      .MAX_VALID (4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .clr_err  (clr_err),
      .err_len  (err_len),
      .err_ack  (err_ack),
      .err_data (err_data),
      .err_any  (err_any),
      .done     (done),
      .xfer_cnt (xfer_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Done monitor: every pulse must match the next expected (channel, cycle).
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (done[c]) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL done_unexpected ch%0d at cycle %0d: got done=1, required none", c, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.ch != c || e.cyc != cyc) begin
                  fails++;
                  $display("FAIL done_match: got ch%0d cycle %0d, required ch%0d cycle %0d", c, cyc, e.ch, e.cyc);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int c, input logic v, input logic a, input logic [7:0] d);
      bus.dValid[c] = v;
      bus.dAck[c]   = a;
      bus.data[c]   = d;
   endtask

   task automatic expect_done(input int c);
      exp_t e;
      e.ch  = c;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic clear_flags();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
   endtask

   function automatic logic [15:0] ecnt(input int n);
`ifdef BUS_PROTOCOL_COUNT_EN
      return 16'(n);
`else
      return 16'(n * 0);
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.dValid = '0;
      bus.dAck   = '0;
      bus.data   = '0;
      step();
      chk("reset_err_len", 32'(err_len), 0);
      chk("reset_err_ack", 32'(err_ack), 0);
      chk("reset_err_any", 32'(err_any), 0);
      chk("reset_xfer_cnt0", 32'(xfer_cnt[0]), 0);
      reset_n = 1'b1;
      step();

      // Legal 3-clock transfer, then back-to-back 2-clock, then 4-clock.
      drv(0, 1, 0, 8'hA5); step();
      drv(0, 1, 0, 8'hA5); step();
      drv(0, 1, 1, 8'hA5); step();
      drv(0, 0, 0, 8'hA5); expect_done(0); step();
      chk("legal3_errs", 32'({err_len, err_ack, err_data}), 0);
      drv(0, 1, 0, 8'h11); step();
      chk("cnt_after_first", 32'(xfer_cnt[0]), 32'(ecnt(1)));
      drv(0, 1, 1, 8'h11); step();
      drv(0, 0, 0, 8'h11); expect_done(0); step();
      drv(0, 1, 0, 8'h22); step();
      drv(0, 1, 0, 8'h22); step();
      drv(0, 1, 0, 8'h22); step();
      drv(0, 1, 1, 8'h22); step();
      drv(0, 0, 0, 8'h22); expect_done(0); step();
      step();
      chk("legal_max_errs", 32'(err_any), 0);
      chk("cnt_after_three", 32'(xfer_cnt[0]), 32'(ecnt(3)));

      // No ack for 5 clocks: err_ack after the 4th.
      drv(0, 1, 0, 8'h5A); step();
      drv(0, 1, 0, 8'h5A); step();
      drv(0, 1, 0, 8'h5A); step();
      chk("noack_3rd", 32'(err_ack), 0);
      drv(0, 1, 0, 8'h5A); step();
      chk("noack_4th", 32'(err_ack), 32'h1);
      drv(0, 1, 0, 8'h5A); step();
      drv(0, 0, 0, 8'h5A); step();
      chk("noack_len", 32'(err_len), 0);
      clear_flags();
      chk("noack_clr", 32'(err_any), 0);

      // Ack in the rise cycle.
      drv(0, 1, 1, 8'h77); step();
      chk("riseack_err_ack", 32'(err_ack), 32'h1);
      chk("riseack_err_any", 32'(err_any), 32'h1);
      drv(0, 0, 0, 8'h77); step();
      clear_flags();

      // Data changes mid-transfer.
      drv(0, 1, 0, 8'h3C); step();
      drv(0, 1, 0, 8'h3D); step();
      chk("data_chg_err_data", 32'(err_data), 32'h1);
      drv(0, 1, 1, 8'h3D); step();
      drv(0, 0, 0, 8'h3D); step();
      chk("data_chg_other", 32'({err_len, err_ack}), 0);
      clear_flags();
      chk("data_chg_clr", 32'(err_any), 0);

      // dValid dropped before ack.
      drv(0, 1, 0, 8'h01); step();
      drv(0, 1, 0, 8'h01); step();
      drv(0, 0, 0, 8'h01); step();
      chk("early_drop_len", 32'(err_len), 32'h1);
      clear_flags();

      // Spurious ack in IDLE; a new error beats a coincident clr_err.
      drv(0, 0, 1, 8'h00); step();
      chk("spurious_ack", 32'(err_ack), 32'h1);
      clr_err = 1'b1; step();
      chk("clr_vs_err", 32'(err_ack), 32'h1);
      drv(0, 0, 0, 8'h00); step();
      clr_err = 1'b0;
      chk("clr_only", 32'(err_ack), 0);

      // dValid held one clock past ack, then reset mid-transfer.
      drv(0, 1, 0, 8'h44); step();
      drv(0, 1, 1, 8'h44); step();
      drv(0, 1, 0, 8'h44); step();
      chk("hold_after_ack_len", 32'(err_len), 32'h1);
      drv(0, 0, 0, 8'h44); step();
      drv(0, 1, 0, 8'h55); step();
      drv(0, 1, 0, 8'h55); step();
      reset_n = 1'b0;
      #1;
      chk("async_reset_errs", 32'({err_len, err_ack, err_data, done}), 0);
      chk("async_reset_cnt0", 32'(xfer_cnt[0]), 0);
      drv(0, 0, 0, 8'h55);
      #1;
      reset_n = 1'b1;
      step();
      step();
      chk("post_reset_quiet", 32'(err_any), 0);
      drv(0, 1, 0, 8'h66); step();
      drv(0, 1, 1, 8'h66); step();
      drv(0, 0, 0, 8'h66); expect_done(0); step();
      step();
      chk("post_reset_cnt0", 32'(xfer_cnt[0]), 32'(ecnt(1)));

      // Ch2 violates while ch0/1/3 complete cleanly.
      for (int c = 0; c < NCH; c++) drv(c, 1, 0, 8'(8'h90 + c));
      step();
      for (int c = 0; c < NCH; c++) drv(c, 1, 0, 8'(8'h90 + c));
      step();
      for (int c = 0; c < NCH; c++) drv(c, 1, (c != 2), 8'(8'h90 + c));
      step();
      for (int c = 0; c < NCH; c++) begin
         if (c == 2) drv(c, 1, 0, 8'h92);
         else begin
            drv(c, 0, 0, 8'(8'h90 + c));
            expect_done(c);
         end
      end
      step();
      chk("multi_err_ack", 32'(err_ack), 32'h4);
      chk("multi_err_other", 32'({err_len, err_data}), 0);
      drv(2, 0, 0, 8'h92); step();
      step();
      chk("multi_cnt0", 32'(xfer_cnt[0]), 32'(ecnt(2)));
      chk("multi_cnt1", 32'(xfer_cnt[1]), 32'(ecnt(1)));
      chk("multi_cnt2", 32'(xfer_cnt[2]), 0);
      chk("multi_cnt3", 32'(xfer_cnt[3]), 32'(ecnt(1)));

      step();
      step();
      chk("done_queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bus_protocol_monitor.md
BUS_PROTOCOL_MONITOR -- requirements
Module: bus_protocol_monitor

Interface
REQ-001 Parameter DATA_W, 8, data width per channel.
REQ-002 Parameter NUM_CH, 1, number of independent channels monitored (1..16).
REQ-003 Parameter MIN_VALID, 2, minimum dValid run length in clocks (>=2).
REQ-004 Parameter MAX_VALID, 4, maximum dValid run length in clocks (>=MIN_VALID, <=15).
REQ-005 clk  input  1  sole clock; all state samples on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 dValid  input  NUM_CH  per-channel master valid.
REQ-008 dAck  input  NUM_CH  per-channel target acknowledge.
REQ-009 data  input  NUM_CH x DATA_W  per-channel data.
REQ-010 clr_err  input  1  synchronous clear of all sticky error flags.
REQ-011 err_len  output  NUM_CH  sticky: dValid run-length/de-assert violation.
REQ-012 err_ack  output  NUM_CH  sticky: dAck timing violation.
REQ-013 err_data  output  NUM_CH  sticky: data changed during transfer.
REQ-014 err_any  output  1  OR of all sticky flags, all channels.
REQ-015 done  output  NUM_CH  one-clock pulse per clean transfer completion.
REQ-016 xfer_cnt  output  NUM_CH x 16  per-channel clean-transfer count.

Function
REQ-017 Each channel SHALL run an independent FSM with states IDLE, ACTIVE, ACKED, ABORT.
REQ-018 IDLE: dValid=1 (rise) SHALL capture data, load run count=1, go ACTIVE; dAck=1 in IDLE SHALL set err_ack (spurious ack).
REQ-019 Rise cycle with dAck=1 SHALL set err_ack and go ABORT.
REQ-020 ACTIVE: every sample SHALL compare data to captured value; mismatch sets err_data (transfer continues).
REQ-021 ACTIVE, dValid=1, dAck=0: count increments; if count reaches MAX_VALID without dAck, set err_ack, go ABORT.
REQ-022 ACTIVE, dValid=1, dAck=1 with count+1 in [MIN_VALID, MAX_VALID]: go ACKED; count+1 < MIN_VALID: set err_ack, go ABORT.
REQ-023 ACTIVE, dValid=0 (dropped before ack): set err_len, go IDLE.
REQ-024 ACKED: dValid=0 SHALL go IDLE and pulse done if no error was set during this transfer; dValid=1 sets err_len, go ABORT.
REQ-025 ABORT: stay until dValid=0, then IDLE; no new errors flagged except err_data none; dAck ignored.
REQ-026 Defaults per (REQ-003/004): legal transfer = dValid high 2..4 clocks, dAck high exactly in last high clock, dValid low next clock.
REQ-027 Error flags and done SHALL be registered, asserting the clock after the violating sample.
REQ-028 Sticky flags SHALL hold until clr_err or reset; clr_err coincident with a new error: error wins (flag stays 1).
REQ-029 err_any SHALL be combinational OR of registered flags.
REQ-030 Back-to-back: dValid low for one clock after ACKED, then high again SHALL start a new transfer normally.

Reset
REQ-031 reset_n low SHALL asynchronously force all FSMs IDLE, counts 0, err_len/err_ack/err_data/done/xfer_cnt 0.
REQ-032 Reset mid-transfer SHALL discard it; no error or done on release; next dValid rise starts fresh.

Configuration
REQ-033 Macro BUS_PROTOCOL_COUNT_EN defined: xfer_cnt increments on each done pulse, saturating at 16'hFFFF, cleared only by reset.
REQ-034 Macro undefined: xfer_cnt tied to 0, no counter registers synthesised.

Structure
REQ-035 Package bus_protocol_pkg SHALL hold the FSM state enum and the counter width constant (16).
REQ-036 Per-channel logic SHALL live in sub-module bus_protocol_ch_monitor, instantiated NUM_CH times via generate.

Verification
REQ-037 Ch0 dValid high 3 clocks, data=8'hA5 stable, dAck high in 3rd, dValid low next -> done pulse, no errors, xfer_cnt=1 (COUNT_EN).
REQ-038 dValid high 5 clocks, dAck never -> err_ack set after 4th high clock; done never pulses.
REQ-039 dAck high in rise cycle+0 with dValid 1 clock before ack (count 1) -> err_ack=1, err_any=1.
REQ-040 data 8'h3C changes to 8'h3D in 2nd clock, otherwise legal -> err_data=1, no done; clr_err -> flags 0.
REQ-041 dValid stays high one clock after dAck -> err_len=1; assert reset_n low mid-transfer -> all outputs 0 immediately.
REQ-042 NUM_CH=4: violation on ch2 only -> only err bit 2 set; other channels complete cleanly with done pulses.
